sha3_absorb: RTL and testbench
==============================

Name: sha3_absorb

Overview:
- Sponge absorb and padding stage sitting directly upstream of keccak_f1600_round.
- Accepts a message as a stream of 64-bit little-endian words and XORs them into a 25-lane state.
- Applies SHA-3 pad10*1 with the domain byte, then hands the state to the permutation over its ready/start/vec handshake and absorbs the returned state.
- After the final permutation it presents the 1600-bit state to the downstream squeeze/digest stage.

Parameters:
- RATE_WORDS, 17, rate in 64-bit lanes (17 = SHA3-256; legal 9..21).
- DOMAIN_BYTE, 8'h06, SHA-3 domain-separation byte XORed at the first pad position.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- init_i  in  1  pulse: clear state, begin new message.
- s_data_i  in  64  message word; byte k = bits [8k+7:8k].
- s_valid_i  in  1  word valid.
- s_last_i  in  1  final word of message.
- s_bytes_i  in  4  valid bytes in the final word, 0..8; only read when s_last_i=1.
- s_ready_o  out  1  word accepted when s_valid_i & s_ready_o.
- perm_ready_i  in  1  ready_o of the permutation.
- perm_start_o  out  1  one-cycle start pulse to the permutation.
- perm_vec_o  out  64x25  state to the permutation (vec_i).
- perm_vec_i  in  64x25  permutation result (vec_o).
- state_o  out  64x25  final absorbed state.
- state_valid_o  out  1  state_o valid.

Behaviour:
- Reset, or any cycle with rst=1: FSM to IDLE, a[*]=0, cnt=0, pad_pending=0, final=0. All outputs 0.
- Lane index = linear 0..24. Word cnt is XORed into a[cnt].
- IDLE: s_ready_o=0. On init_i: a[*]=0, cnt=0 -> ABSORB. Other inputs are ignored.
- ABSORB: s_ready_o=1. On accept:
  - Not last: a[cnt]^=s_data_i, cnt++. If cnt becomes RATE_WORDS -> PSTART (cnt resets to 0 on return).
  - Last: bytes at positions >= s_bytes_i are masked to 0 before the XOR.
    - If s_bytes_i<8: XOR DOMAIN_BYTE at byte s_bytes_i of lane cnt, XOR 8'h80 into byte 7 of lane RATE_WORDS-1 (same byte gives 8'h86). Set final=1 -> PSTART.
    - If s_bytes_i=8 and cnt<RATE_WORDS-1: DOMAIN_BYTE goes to byte 0 of lane cnt+1 plus the 8'h80. final=1 -> PSTART.
    - If s_bytes_i=8 and cnt=RATE_WORDS-1: pad_pending=1 -> PSTART.
  - s_bytes_i>8 is treated as 8.
- PSTART: perm_vec_o=a, held stable. When perm_ready_i=1, drive perm_start_o=1 for exactly one cycle -> PWAIT.
- PWAIT: perm_vec_o held. Track perm_ready_i going low. On its first subsequent 1 (low->high), capture a<=perm_vec_i, cnt=0.
  - final -> DONE.
  - pad_pending -> PAD.
  - otherwise -> ABSORB.
- PAD: a[0]^=DOMAIN_BYTE (byte 0), a[RATE_WORDS-1]^=8'h80<<56, pad_pending=0, final=1 -> PSTART. One cycle, s_ready_o=0.
- DONE: state_valid_o=1, state_o=a, s_ready_o=0. init_i clears a and cnt, drops state_valid_o next cycle -> ABSORB.
- init_i outside IDLE/DONE is ignored. s_valid_i outside ABSORB is ignored (no accept).
- Capacity lanes RATE_WORDS..24 are never XORed by input; they change only by permutation capture.
- Latency: an accepted word is visible in a[] next cycle. perm_start_o fires no earlier than 1 cycle after the block-completing word.

Optional Feature:
- Macro SHA3_ABSORB_SHAKE_EN.
- Defined: adds input port shake_i (1 bit), sampled on init_i. When 1, the domain byte is 8'h1F for the whole message, otherwise DOMAIN_BYTE.
- Undefined: no shake_i port; DOMAIN_BYTE is always used.

Test Plan:
- Empty message: init, one word s_last_i=1, s_bytes_i=0, data=FFFF.. -> perm_vec_o lane0=64'h06, lane16=64'h8000000000000000, others 0; exactly one perm_start_o; DONE with state_o = stub perm_vec_i.
- 3-byte message 0x636261, s_bytes_i=3, RATE_WORDS=17 -> lane0=64'h0000000006636261.
- Exactly 17 full words, last s_bytes_i=8 -> two perm_start_o pulses. Second block lane0=64'h06, lane16=64'h8000000000000000 XORed onto the stub result.
- Last word at cnt=16 with s_bytes_i=7 -> lane16 byte7=8'h86.
- Permutation stub holds perm_ready_i=0 for 30 cycles -> perm_vec_o stable throughout, no capture until it rises, s_ready_o=0.
- rst asserted mid-PWAIT -> next cycle all outputs 0 and IDLE; a new init plus message yields a clean result.

Source files
------------

// File: rtl/sha3_absorb.sv
// ============================================================================
//  Module      : sha3_absorb
//  Description : SHA-3 sponge absorb + pad10*1 stage feeding keccak_f1600_round.
//                Optional macro SHA3_ABSORB_SHAKE_EN adds shake_i (domain 8'h1F).
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module sha3_absorb #(
    parameter int         RATE_WORDS  = 17,
    parameter logic [7:0] DOMAIN_BYTE = 8'h06
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          init_i,
`ifdef SHA3_ABSORB_SHAKE_EN
    input  logic          shake_i,
`endif
    input  logic [63:0]   s_data_i,
    input  logic          s_valid_i,
    input  logic          s_last_i,
    input  logic [3:0]    s_bytes_i,
    output logic          s_ready_o,
    input  logic          perm_ready_i,
    output logic          perm_start_o,
    output logic [1599:0] perm_vec_o,
    input  logic [1599:0] perm_vec_i,
    output logic [1599:0] state_o,
    output logic          state_valid_o
);

    localparam int          LANES       = 25;
    localparam logic [4:0]  C_LAST_LANE = 5'(RATE_WORDS - 1);
    localparam logic [63:0] C_PAD_END   = 64'h8000_0000_0000_0000;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ABSORB = 3'd1,
        ST_PSTART = 3'd2,
        ST_PWAIT  = 3'd3,
        ST_PAD    = 3'd4,
        ST_DONE   = 3'd5
    } state_t;

    state_t      state_q, state_d;
    logic [63:0] a_q [LANES];
    logic [63:0] a_d [LANES];
    logic [63:0] w_vec_in [LANES];
    logic [4:0]  cnt_q, cnt_d;
    logic        pad_pending_q, pad_pending_d;
    logic        final_q, final_d;
    logic        seen_low_q, seen_low_d;
    logic [3:0]  w_bytes;
    logic [63:0] w_mask;
    logic [7:0]  w_dom;
    logic [63:0] w_dom_lane;

`ifdef SHA3_ABSORB_SHAKE_EN
    logic shake_q, shake_d;

    always_comb begin
        shake_d = shake_q;
        if (init_i && (state_q == ST_IDLE || state_q == ST_DONE)) begin
            shake_d = shake_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) shake_q <= 1'b0;
        else     shake_q <= shake_d;
    end

    assign w_dom = shake_q ? 8'h1F : DOMAIN_BYTE;
`else
    assign w_dom = DOMAIN_BYTE;
`endif

    assign w_dom_lane = {56'd0, w_dom};
    assign w_bytes    = (s_bytes_i > 4'd8) ? 4'd8 : s_bytes_i;

    // Keep only the leading w_bytes bytes of the final word.
    always_comb begin
        w_mask = '0;
        for (int k = 0; k < 8; k++) begin
            if (4'(k) < w_bytes) w_mask[8*k +: 8] = 8'hFF;
        end
    end

    generate
        for (genvar i = 0; i < LANES; i++) begin : g_lanes
            assign perm_vec_o[64*i +: 64] = a_q[i];
            assign state_o[64*i +: 64]    = (state_q == ST_DONE) ? a_q[i] : 64'd0;
            assign w_vec_in[i]            = perm_vec_i[64*i +: 64];
        end
    endgenerate

    assign s_ready_o     = (state_q == ST_ABSORB);
    assign perm_start_o  = (state_q == ST_PSTART) && perm_ready_i && !rst;
    assign state_valid_o = (state_q == ST_DONE);

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        pad_pending_d = pad_pending_q;
        final_d       = final_q;
        seen_low_d    = seen_low_q;
        for (int i = 0; i < LANES; i++) a_d[i] = a_q[i];

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (init_i) begin
                    for (int i = 0; i < LANES; i++) a_d[i] = '0;
                    cnt_d         = '0;
                    pad_pending_d = 1'b0;
                    final_d       = 1'b0;
                    state_d       = ST_ABSORB;
                end
            end
            ST_ABSORB: begin
                if (s_valid_i) begin
                    if (!s_last_i) begin
                        a_d[cnt_q] = a_q[cnt_q] ^ s_data_i;
                        cnt_d      = cnt_q + 5'd1;
                        if (cnt_q == C_LAST_LANE) state_d = ST_PSTART;
                    end else begin
                        a_d[cnt_q] = a_q[cnt_q] ^ (s_data_i & w_mask);
                        state_d    = ST_PSTART;
                        if (w_bytes != 4'd8) begin
                            a_d[cnt_q]       = a_d[cnt_q] ^ (w_dom_lane << {w_bytes[2:0], 3'b000});
                            a_d[C_LAST_LANE] = a_d[C_LAST_LANE] ^ C_PAD_END;
                            final_d          = 1'b1;
                        end else if (cnt_q != C_LAST_LANE) begin
                            a_d[cnt_q + 5'd1] = a_d[cnt_q + 5'd1] ^ w_dom_lane;
                            a_d[C_LAST_LANE]  = a_d[C_LAST_LANE] ^ C_PAD_END;
                            final_d           = 1'b1;
                        end else begin
                            // Block is full: padding needs a block of its own.
                            pad_pending_d = 1'b1;
                        end
                    end
                end
            end
            ST_PSTART: begin
                if (perm_ready_i) begin
                    seen_low_d = 1'b0;
                    state_d    = ST_PWAIT;
                end
            end
            ST_PWAIT: begin
                // Capture only on a rising ready, never on the stale high.
                if (!perm_ready_i) begin
                    seen_low_d = 1'b1;
                end else if (seen_low_q) begin
                    for (int i = 0; i < LANES; i++) a_d[i] = w_vec_in[i];
                    cnt_d = '0;
                    if (final_q)            state_d = ST_DONE;
                    else if (pad_pending_q) state_d = ST_PAD;
                    else                    state_d = ST_ABSORB;
                end
            end
            ST_PAD: begin
                a_d[0]           = a_q[0] ^ w_dom_lane;
                a_d[C_LAST_LANE] = a_d[C_LAST_LANE] ^ C_PAD_END;
                pad_pending_d    = 1'b0;
                final_d          = 1'b1;
                state_d          = ST_PSTART;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            for (int i = 0; i < LANES; i++) a_q[i] <= '0;
            cnt_q         <= '0;
            pad_pending_q <= 1'b0;
            final_q       <= 1'b0;
            seen_low_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            for (int i = 0; i < LANES; i++) a_q[i] <= a_d[i];
            cnt_q         <= cnt_d;
            pad_pending_q <= pad_pending_d;
            final_q       <= final_d;
            seen_low_q    <= seen_low_d;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_sha3_absorb.sv
// ============================================================================
//  Module      : tb_sha3_absorb
//  Description : Self-checking bench for sha3_absorb with a permutation stub
//                and a byte-level sponge reference model.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_sha3_absorb;

    localparam int R  = 17;
    localparam int RB = R * 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          init_i = 1'b0;
    logic [63:0]   s_data_i = '0;
    logic          s_valid_i = 1'b0;
    logic          s_last_i = 1'b0;
    logic [3:0]    s_bytes_i = '0;
    logic          s_ready_o;
    logic          perm_ready_i = 1'b1;
    logic          perm_start_o;
    logic [1599:0] perm_vec_o;
    logic [1599:0] perm_vec_i = '0;
    logic [1599:0] state_o;
    logic          state_valid_o;

    sha3_absorb #(.RATE_WORDS(R), .DOMAIN_BYTE(8'h06)) dut (
        .clk          (clk),
        .rst          (rst),
        .init_i       (init_i),
        .s_data_i     (s_data_i),
        .s_valid_i    (s_valid_i),
        .s_last_i     (s_last_i),
        .s_bytes_i    (s_bytes_i),
        .s_ready_o    (s_ready_o),
        .perm_ready_i (perm_ready_i),
        .perm_start_o (perm_start_o),
        .perm_vec_o   (perm_vec_o),
        .perm_vec_i   (perm_vec_i),
        .state_o      (state_o),
        .state_valid_o(state_valid_o)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic chk64(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chkvec(input string name, input logic [1599:0] act, input logic [1599:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            for (int i = 0; i < 25; i++) begin
                if (act[64*i +: 64] !== exp[64*i +: 64]) begin
                    $display("FAIL %s: lane %0d got %h expected %h", name, i,
                             act[64*i +: 64], exp[64*i +: 64]);
                    break;
                end
            end
        end
    endtask

    // Arbitrary but deterministic stand-in for Keccak-f.
    function automatic logic [1599:0] perm_f(input logic [1599:0] x);
        logic [1599:0] y;
        logic [63:0]   v;
        int            r;
        y = '0;
        for (int i = 0; i < 25; i++) begin
            v = x[64*((i+3)%25) +: 64];
            r = i % 63 + 1;
            y[64*i +: 64] = ((v << r) | (v >> (64 - r))) ^ {32'h9E3779B9, 32'(i)};
        end
        return y;
    endfunction

    // Permutation stub
    int            stub_lat   = 2;
    int            stub_phase = 0;
    int            stub_cnt   = 0;
    int            n_starts   = 0;
    logic [1599:0] stub_vec   = '0;
    logic [1599:0] obs_vec[$];

    always @(negedge clk) begin
        if (rst) begin
            perm_ready_i = 1'b1;
            stub_phase   = 0;
        end else if (perm_start_o) begin
            n_starts++;
            stub_vec = perm_vec_o;
            obs_vec.push_back(perm_vec_o);
            stub_phase = 1;
            stub_cnt   = stub_lat;
        end else if (stub_phase == 1) begin
            perm_ready_i = 1'b0;
            stub_phase   = 2;
        end else if (stub_phase == 2) begin
            chkvec("vec_stable", perm_vec_o, stub_vec);
            chk64("ready_in_wait", {63'd0, s_ready_o}, 64'd0);
            if (stub_cnt <= 0) begin
                perm_vec_i   = perm_f(stub_vec);
                perm_ready_i = 1'b1;
                stub_phase   = 0;
            end else begin
                stub_cnt--;
            end
        end
    end

    // Reference model: byte-string pad10*1 sponge.
    logic [63:0]   wq[$];
    logic [1599:0] exp_vec[$];
    logic [1599:0] exp_final;

    task automatic build_model(input int lastb_raw);
        int            nb, len, padded;
        byte unsigned  p[];
        logic [1599:0] st;
        nb     = (lastb_raw > 8) ? 8 : lastb_raw;
        len    = 8 * (wq.size() - 1) + nb;
        padded = (len / RB + 1) * RB;
        p = new[padded];
        foreach (p[i]) p[i] = 8'h00;
        for (int i = 0; i < len; i++) p[i] = wq[i/8][8*(i%8) +: 8];
        p[len]        = p[len] ^ 8'h06;
        p[padded - 1] = p[padded - 1] ^ 8'h80;
        st = '0;
        exp_vec.delete();
        for (int b = 0; b < padded / RB; b++) begin
            for (int j = 0; j < RB; j++) st[8*j +: 8] = st[8*j +: 8] ^ p[b*RB + j];
            exp_vec.push_back(st);
            st = perm_f(st);
        end
        exp_final = st;
    endtask

    task automatic send_msg(input int lastb_raw, input int gapmax);
        int to;
        for (int w = 0; w < wq.size(); w++) begin
            s_valid_i = 1'b0;
            repeat ($urandom_range(0, gapmax)) @(negedge clk);
            s_valid_i = 1'b1;
            s_data_i  = wq[w];
            s_last_i  = (w == wq.size() - 1);
            s_bytes_i = s_last_i ? 4'(lastb_raw) : 4'($urandom);
            to = 0;
            while (!s_ready_o && to < 5000) begin
                @(negedge clk);
                to++;
            end
            if (to >= 5000) begin
                failures++;
                $display("FAIL accept_timeout: word %0d not accepted", w);
                break;
            end
            @(negedge clk);
        end
        s_valid_i = 1'b0;
        s_last_i  = 1'b0;
    endtask

    task automatic run_msg(input int lastb_raw, input int lat, input int gapmax);
        int to;
        obs_vec.delete();
        n_starts = 0;
        stub_lat = lat;
        build_model(lastb_raw);
        @(negedge clk);
        init_i = 1'b1;
        @(negedge clk);
        init_i = 1'b0;
        chk64("valid_after_init", {63'd0, state_valid_o}, 64'd0);
        chk64("ready_after_init", {63'd0, s_ready_o}, 64'd1);
        send_msg(lastb_raw, gapmax);
        to = 0;
        while (!state_valid_o && to < 5000) begin
            @(negedge clk);
            to++;
        end
        checks++;
        if (to >= 5000) begin
            failures++;
            $display("FAIL done_timeout: state_valid_o never rose");
        end
        chk64("start_count", 64'(n_starts), 64'(exp_vec.size()));
        for (int i = 0; i < obs_vec.size() && i < exp_vec.size(); i++)
            chkvec("perm_vec", obs_vec[i], exp_vec[i]);
        chkvec("state_o", state_o, exp_final);
        chk64("ready_in_done", {63'd0, s_ready_o}, 64'd0);
    endtask

    typedef struct {
        int          nwords;
        int          lastb;
        logic [63:0] data0;
        int          starts;
        logic [63:0] d_lane0;
        logic [63:0] d_lanel;
    } vec_t;

    vec_t tbl[6];

    initial begin
        #800000;
        failures++;
        $display("FAIL watchdog: simulation did not complete");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        logic [1599:0] last, prev;
        int            to, nw, lb;

        tbl[0] = '{1,  0,  64'hFFFF_FFFF_FFFF_FFFF, 1, 64'h0000_0000_0000_0006, 64'h8000_0000_0000_0000};
        tbl[1] = '{1,  3,  64'hFFFF_FFFF_FF63_6261, 1, 64'h0000_0000_0663_6261, 64'h8000_0000_0000_0000};
        tbl[2] = '{17, 8,  64'h0101_0101_0101_0101, 2, 64'h0000_0000_0000_0006, 64'h8000_0000_0000_0000};
        tbl[3] = '{17, 7,  64'h0101_0101_0101_0101, 1, 64'h0101_0101_0101_0101, 64'h8611_1111_1111_1111};
        tbl[4] = '{16, 8,  64'h0101_0101_0101_0101, 1, 64'h0101_0101_0101_0101, 64'h8000_0000_0000_0006};
        tbl[5] = '{1,  12, 64'h1122_3344_5566_7788, 1, 64'h1122_3344_5566_7788, 64'h8000_0000_0000_0000};

        // Reset state
        @(posedge clk);
        #1;
        chk64("rst_ready", {63'd0, s_ready_o}, 64'd0);
        chk64("rst_start", {63'd0, perm_start_o}, 64'd0);
        chk64("rst_valid", {63'd0, state_valid_o}, 64'd0);
        chkvec("rst_vec", perm_vec_o, '0);
        chkvec("rst_state", state_o, '0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk64("idle_ready", {63'd0, s_ready_o}, 64'd0);

        for (int t = 0; t < 6; t++) begin
            wq.delete();
            wq.push_back(tbl[t].data0);
            for (int w = 1; w < tbl[t].nwords; w++) wq.push_back({8{8'(w + 1)}});
            run_msg(tbl[t].lastb, 2, 1);
            chk64("tbl_starts", 64'(n_starts), 64'(tbl[t].starts));
            if (obs_vec.size() > 0) begin
                last = obs_vec[obs_vec.size() - 1];
                prev = (obs_vec.size() > 1) ? perm_f(obs_vec[obs_vec.size() - 2]) : '0;
                chk64("delta_lane0", last[63:0] ^ prev[63:0], tbl[t].d_lane0);
                chk64("delta_laneL", last[64*(R-1) +: 64] ^ prev[64*(R-1) +: 64], tbl[t].d_lanel);
            end
        end

        // Long permutation stall
        wq.delete();
        wq.push_back({$urandom, $urandom});
        wq.push_back({$urandom, $urandom});
        run_msg(5, 30, 0);

        // Randomised messages
        for (int n = 0; n < 25; n++) begin
            wq.delete();
            nw = $urandom_range(1, 2 * R + 3);
            for (int w = 0; w < nw; w++) wq.push_back({$urandom, $urandom});
            lb = $urandom_range(0, 8);
            if (lb == 8 && $urandom_range(0, 1) == 1) lb = $urandom_range(9, 15);
            run_msg(lb, $urandom_range(0, 5), 2);
        end

        // Reset while the permutation is in flight
        wq.delete();
        wq.push_back({$urandom, $urandom});
        stub_lat = 40;
        @(negedge clk);
        init_i = 1'b1;
        @(negedge clk);
        init_i = 1'b0;
        send_msg(3, 0);
        to = 0;
        while (stub_phase != 2 && to < 200) begin
            @(negedge clk);
            to++;
        end
        chk64("reached_pwait", 64'(stub_phase), 64'd2);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk64("mid_rst_ready", {63'd0, s_ready_o}, 64'd0);
        chk64("mid_rst_start", {63'd0, perm_start_o}, 64'd0);
        chk64("mid_rst_valid", {63'd0, state_valid_o}, 64'd0);
        chkvec("mid_rst_vec", perm_vec_o, '0);
        chkvec("mid_rst_state", state_o, '0);
        @(negedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk64("post_rst_idle", {63'd0, s_ready_o}, 64'd0);
        wq.delete();
        for (int w = 0; w < 20; w++) wq.push_back({$urandom, $urandom});
        run_msg(6, 3, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
